// File: rtl/gpu_pkg.sv
// Shared GPU encodings: scheduler (core) states, LSU states and default datapath widths.
package gpu_pkg;

    localparam int ADDR_BITS_DEF = 8;
    localparam int DATA_BITS_DEF = 8;

    localparam logic [2:0] CORE_FETCH   = 3'd0;
    localparam logic [2:0] CORE_DECODE  = 3'd1;
    localparam logic [2:0] CORE_REQUEST = 3'd2;
    localparam logic [2:0] CORE_WAIT    = 3'd3;
    localparam logic [2:0] CORE_EXECUTE = 3'd4;
    localparam logic [2:0] CORE_UPDATE  = 3'd5;
    localparam logic [2:0] CORE_DONE    = 3'd6;

    localparam logic [1:0] LSU_IDLE       = 2'd0;
    localparam logic [1:0] LSU_REQUESTING = 2'd1;
    localparam logic [1:0] LSU_WAITING    = 2'd2;
    localparam logic [1:0] LSU_DONE       = 2'd3;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } lsu_op_e;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one memory read or write per LDR/STR and
// returns load data to the register file.
//   state      | meaning
//   IDLE       | no instruction in flight
//   REQUESTING | op latched; valid/address/data driven on next edge
//   WAITING    | request pending until the channel's ready is sampled high
//   DONE       | transaction finished; waiting for scheduler UPDATE
module lsu
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    logic [1:0]           state_q, state_d;
    lsu_op_e              op_q, op_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] out_q, out_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        out_d      = out_q;
        if (enable) begin
            case (state_q)
                LSU_IDLE: begin
                    // read wins when the decoder flags both
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state_d = LSU_REQUESTING;
                        op_d    = decoded_mem_read_enable ? OP_READ : OP_WRITE;
                    end
                end
                LSU_REQUESTING: begin
                    if (op_q == OP_READ) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rs[ADDR_BITS-1:0];
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rs[ADDR_BITS-1:0];
                        wr_data_d  = rt;
                    end
                    state_d = LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (op_q == OP_READ && mem_read_ready) begin
                        out_d      = mem_read_data;
                        rd_valid_d = 1'b0;
                        state_d    = LSU_DONE;
                    end else if (op_q == OP_WRITE && mem_write_ready) begin
                        wr_valid_d = 1'b0;
                        state_d    = LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            op_q       <= OP_WRITE;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_q      <= out_d;
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;

endmodule
